// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter and the divider bench.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  // Match counter width; LOCK_COUNT is at most 15.
  localparam int unsigned MATCH_W        = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history register; strobes on any level change.
// Deliberately unreset so reset release or enable never fakes an edge.
module sync_edge_detect (
  input  logic clk,
  input  logic sig_in,
  output logic edge_stb
);

  logic sync_1;
  logic sync_2;
  logic hist;

  // Synchronise the asynchronous input and keep one cycle of history.
  always_ff @(posedge clk) begin
    sync_1 <= sig_in;
    sync_2 <= sync_1;
    hist   <= sync_2;
  end

  assign edge_stb = sync_2 ^ hist;

endmodule

// File: rtl/clk_period_meter.sv
// Half-period meter for a divided clock; reports the generating divisor.
// Optional: define CLK_PERIOD_METER_TOLERANCE_EN to accept +/-1 as a match.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  meter_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     prev_q, prev_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic                 first_q, first_d;
  logic [CNT_W-1:0]     hp_d;
  logic                 pv_d;
  logic                 lk_d;
  logic                 ov_d;
  logic                 edge_stb;
  logic                 is_match;

  sync_edge_detect u_sync (
    .clk      (clk),
    .sig_in   (sig_in),
    .edge_stb (edge_stb)
  );

`ifdef CLK_PERIOD_METER_TOLERANCE_EN
  logic [CNT_W:0] diff;

  // Absolute difference in one extra bit so the extremes never alias.
  always_comb begin
    diff = '0;
    if ({1'b0, cnt_q} >= {1'b0, prev_q}) diff = {1'b0, cnt_q} - {1'b0, prev_q};
    else                                 diff = {1'b0, prev_q} - {1'b0, cnt_q};
    is_match = (diff <= (CNT_W+1)'(1));
  end
`else
  // Exact comparison against the previous measurement.
  always_comb begin
    is_match = (cnt_q == prev_q);
  end
`endif

  // Next-state and datapath: idle/acquire/measure with lock and overflow tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    match_d = match_q;
    first_d = first_q;
    hp_d    = half_period;
    pv_d    = 1'b0;
    lk_d    = locked;
    ov_d    = overflow;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      match_d = '0;
      first_d = 1'b1;
      lk_d    = 1'b0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
        ACQUIRE: begin
          cnt_d = '0;
          if (edge_stb) begin
            state_d = MEASURE;
            first_d = 1'b1;
          end
        end
        MEASURE: begin
          if (edge_stb) begin
            cnt_d   = '0;
            hp_d    = cnt_q;
            pv_d    = 1'b1;
            ov_d    = 1'b0;
            prev_d  = cnt_q;
            first_d = 1'b0;
            if (first_q) begin
              match_d = '0;
              lk_d    = 1'b0;
            end else if (is_match) begin
              if (match_q < LOCK_MAX) match_d = match_q + MATCH_W'(1);
              lk_d = (match_d == LOCK_MAX);
            end else begin
              match_d = '0;
              lk_d    = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            // No edge within the counter range: give up and reacquire.
            state_d = ACQUIRE;
            cnt_d   = '0;
            match_d = '0;
            lk_d    = 1'b0;
            ov_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prev_q       <= '0;
      match_q      <= '0;
      first_q      <= 1'b1;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      match_q      <= match_d;
      first_q      <= first_d;
      half_period  <= hp_d;
      period_valid <= pv_d;
      locked       <= lk_d;
      overflow     <= ov_d;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes expected
// (half_period, locked) pairs, a negedge monitor pops them on period_valid.
`timescale 1ns/1ps
module tb_clk_period_meter;

`ifdef CLK_PERIOD_METER_TOLERANCE_EN
  localparam bit TOL = 1'b1;
`else
  localparam bit TOL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] half_period;
  logic       period_valid;
  logic       locked;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hp_q[$];
  bit exp_lk_q[$];

  clk_period_meter dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sig_in       (sig_in),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Toggle sig_in, record the expected report for the interval it closes,
  // then hold the new level for 'hold' clk cycles (interval = divisor + 1).
  task automatic tog(input int exp_hp, input bit vld, input bit lk, input int hold);
    sig_in = ~sig_in;
    if (vld) begin
      exp_hp_q.push_back(exp_hp);
      exp_lk_q.push_back(lk);
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every period_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (period_valid) begin
      if (exp_hp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("sb_half_period", int'(half_period), exp_hp_q.pop_front());
        chk("sb_locked", int'(locked), int'(exp_lk_q.pop_front()));
        chk("sb_overflow_clear", int'(overflow), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_half_period", int'(half_period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Divisor 5: lock on the 4th valid.
    tog(0, 1'b0, 1'b0, 6);
    for (int i = 0; i < 6; i++) tog(5, 1'b1, i >= 3, 6);

    // Switch to divisor 7: first 7 drops lock, 4th consecutive 7 relocks.
    tog(5, 1'b1, 1'b1, 8);
    tog(7, 1'b1, 1'b0, 8);
    tog(7, 1'b1, 1'b0, 8);
    tog(7, 1'b1, 1'b0, 8);
    tog(7, 1'b1, 1'b1, 8);
    tog(7, 1'b1, 1'b1, 256);

    // Divisor 255: largest legal value, edge beats overflow.
    tog(255, 1'b1, 1'b0, 256);
    tog(255, 1'b1, 1'b0, 256);
    tog(255, 1'b1, 1'b0, 256);
    tog(255, 1'b1, 1'b1, 0);

    // Stop sig_in: overflow exactly 256 cycles after the last measured edge.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_valid && n < 20);
    chk("last_255_valid_seen", int'(period_valid), 1);
    n = 0;
    while (!overflow && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_delay", n, 256);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_locked", int'(locked), 0);
    chk("ovf_hp_hold", int'(half_period), 255);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", int'(overflow), 1);
    @(posedge clk); #1;

    // Divisor 0: toggle every cycle after reacquisition.
    tog(0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 7; i++) tog(0, 1'b1, i >= 3, 1);
    tog(0, 1'b1, 1'b1, 6);
    tog(5, 1'b1, 1'b0, 6);
    tog(5, 1'b1, 1'b0, 4);

    // Reset pulse mid-interval.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_half_period", int'(half_period), 0);
    chk("midrst_valid", int'(period_valid), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // First edge after reset is acquisition only; then relock on 5.
    tog(0, 1'b0, 1'b0, 6);
    tog(5, 1'b1, 1'b0, 6);
    tog(5, 1'b1, 1'b0, 6);
    tog(5, 1'b1, 1'b0, 6);
    tog(5, 1'b1, 1'b1, 3);

    // Enable dropped mid-interval: lock/overflow clear, half_period holds.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_half_period", int'(half_period), 5);
    chk("dis_valid", int'(period_valid), 0);
    chk("dis_locked", int'(locked), 0);
    chk("dis_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Reacquire, then alternate 5/6 intervals.
    tog(0, 1'b0, 1'b0, 6);
    tog(5, 1'b1, 1'b0, 7);
    tog(6, 1'b1, 1'b0, 6);
    tog(5, 1'b1, 1'b0, 7);
    tog(6, 1'b1, TOL, 6);
    tog(5, 1'b1, TOL, 7);
    tog(6, 1'b1, TOL, 0);

    repeat (10) @(negedge clk);
    chk("sb_drained", exp_hp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
